// File: rtl/arm_pkg.sv
// Shared ARM condition/flag definitions: NZCV bit positions, condition codes, FSM encoding.
package arm_pkg;

    localparam int unsigned NZCV_W = 4;
    localparam int unsigned COND_W = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [COND_W-1:0] COND_EQ = 4'h0;
    localparam logic [COND_W-1:0] COND_NE = 4'h1;
    localparam logic [COND_W-1:0] COND_CS = 4'h2;
    localparam logic [COND_W-1:0] COND_CC = 4'h3;
    localparam logic [COND_W-1:0] COND_MI = 4'h4;
    localparam logic [COND_W-1:0] COND_PL = 4'h5;
    localparam logic [COND_W-1:0] COND_VS = 4'h6;
    localparam logic [COND_W-1:0] COND_VC = 4'h7;
    localparam logic [COND_W-1:0] COND_HI = 4'h8;
    localparam logic [COND_W-1:0] COND_LS = 4'h9;
    localparam logic [COND_W-1:0] COND_GE = 4'hA;
    localparam logic [COND_W-1:0] COND_LT = 4'hB;
    localparam logic [COND_W-1:0] COND_GT = 4'hC;
    localparam logic [COND_W-1:0] COND_LE = 4'hD;
    localparam logic [COND_W-1:0] COND_AL = 4'hE;
    localparam logic [COND_W-1:0] COND_NV = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } cond_state_e;

endpackage

// File: rtl/arm_cond_eval.sv
// Combinational ARM condition-field evaluator against an NZCV nibble.
module arm_cond_eval
    import arm_pkg::*;
#(
    parameter bit NV_NEVER = 1'b1
) (
    input  logic [COND_W-1:0] cond_i,
    input  logic [NZCV_W-1:0] nzcv_i,
    output logic              pass_o
);

    logic n, z, c, v;

    always_comb begin
        n = nzcv_i[FLAG_N];
        z = nzcv_i[FLAG_Z];
        c = nzcv_i[FLAG_C];
        v = nzcv_i[FLAG_V];
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = ~z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = ~c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = ~n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = ~v;
            COND_HI: pass_o = c & ~z;
            COND_LS: pass_o = ~c | z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = ~z & (n == v);
            COND_LE: pass_o = z | (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = ~NV_NEVER;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_cond_status_unit.sv
// NZCV status register with in-flight writer tracking and a stalling, registered
// condition-evaluation request/response channel.
module arm_cond_status_unit
    import arm_pkg::*;
#(
    parameter int unsigned PEND_W   = 2,
    parameter bit          NV_NEVER = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NZCV_W-1:0] FLAGS_IN,
    input  logic              FLAGS_WE,
    input  logic              FLAGS_ISSUE,
    output logic [NZCV_W-1:0] FLAGS,
    input  logic [COND_W-1:0] COND,
    input  logic              COND_VALID,
    output logic              COND_READY,
    output logic              PASS,
    output logic              RESP_VALID,
    input  logic              RESP_READY,
    output logic [PEND_W-1:0] PENDING,
    output logic              PEND_ERR
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    cond_state_e       state_q, state_d;
    logic [NZCV_W-1:0] flags_q, flags_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              err_q, err_d;
    logic [COND_W-1:0] cond_q, cond_d;
    logic              pass_q, pass_d;
    logic              clear, accept, load_pass, latch_cond, eval_pass;
    logic [COND_W-1:0] eval_cond;

    // Effective flags forward a same-cycle ALU write into the evaluation.
    assign flags_d = FLAGS_WE ? FLAGS_IN : flags_q;
    assign clear   = (pend_q == '0) |
                     ((pend_q == PEND_W'(1)) & FLAGS_WE & ~FLAGS_ISSUE);
    assign accept  = COND_VALID & COND_READY;

    always_comb begin
        pend_d = pend_q;
        err_d  = err_q;
        if (FLAGS_ISSUE && !FLAGS_WE) begin
            if (pend_q == PEND_MAX) err_d  = 1'b1;
            else                    pend_d = pend_q + PEND_W'(1);
        end else if (FLAGS_WE && !FLAGS_ISSUE && (pend_q != '0)) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_pass  = 1'b0;
        latch_cond = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (clear) begin
                        state_d   = ST_RESP;
                        load_pass = 1'b1;
                    end else begin
                        state_d    = ST_WAIT;
                        latch_cond = 1'b1;
                    end
                end else if (state_q == ST_RESP && RESP_READY) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (clear) begin
                    state_d   = ST_RESP;
                    load_pass = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        COND_READY = (state_q == ST_IDLE) | ((state_q == ST_RESP) & RESP_READY);
        RESP_VALID = (state_q == ST_RESP);
        eval_cond  = (state_q == ST_WAIT) ? cond_q : COND;
    end

    arm_cond_eval #(.NV_NEVER(NV_NEVER)) u_eval (
        .cond_i (eval_cond),
        .nzcv_i (flags_d),
        .pass_o (eval_pass)
    );

    assign pass_d = load_pass  ? eval_pass : pass_q;
    assign cond_d = latch_cond ? COND      : cond_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
            cond_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            flags_q <= flags_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            cond_q  <= cond_d;
            pass_q  <= pass_d;
        end
    end

    assign FLAGS    = flags_q;
    assign PENDING  = pend_q;
    assign PEND_ERR = err_q;
    assign PASS     = pass_q;

endmodule

// File: tb/tb_arm_cond_status_unit.sv
// Directed and random checks of arm_cond_status_unit against a cycle-level reference model.
module tb_arm_cond_status_unit;

    localparam int unsigned PEND_W = 2;
    localparam int PMAX = (1 << PEND_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        FLAGS_IN;
    logic              FLAGS_WE, FLAGS_ISSUE, COND_VALID, RESP_READY;
    logic [3:0]        COND;
    logic [3:0]        FLAGS, FLAGS1;
    logic              COND_READY, PASS, RESP_VALID, PEND_ERR;
    logic              COND_READY1, PASS1, RESP_VALID1, PEND_ERR1;
    logic [PEND_W-1:0] PENDING, PENDING1;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int m_flags, m_pend, m_wcond;
    bit m_err, m_wait, m_rv, m_pass_nv1, m_pass_nv0;

    always #5 clk = ~clk;

    arm_cond_status_unit #(.PEND_W(PEND_W), .NV_NEVER(1'b1)) u_dut (
        .clk(clk), .reset(reset), .FLAGS_IN(FLAGS_IN), .FLAGS_WE(FLAGS_WE),
        .FLAGS_ISSUE(FLAGS_ISSUE), .FLAGS(FLAGS), .COND(COND), .COND_VALID(COND_VALID),
        .COND_READY(COND_READY), .PASS(PASS), .RESP_VALID(RESP_VALID),
        .RESP_READY(RESP_READY), .PENDING(PENDING), .PEND_ERR(PEND_ERR)
    );

    arm_cond_status_unit #(.PEND_W(PEND_W), .NV_NEVER(1'b0)) u_dut_nv0 (
        .clk(clk), .reset(reset), .FLAGS_IN(FLAGS_IN), .FLAGS_WE(FLAGS_WE),
        .FLAGS_ISSUE(FLAGS_ISSUE), .FLAGS(FLAGS1), .COND(COND), .COND_VALID(COND_VALID),
        .COND_READY(COND_READY1), .PASS(PASS1), .RESP_VALID(RESP_VALID1),
        .RESP_READY(RESP_READY), .PENDING(PENDING1), .PEND_ERR(PEND_ERR1)
    );

    // Conditions come in complementary pairs: cond/2 picks the test, odd codes invert it.
    function automatic bit ref_pass(input int cond, input int nzcv, input bit nv_never);
        int n, z, c, v;
        bit base;
        n = (nzcv / 8) % 2;
        z = (nzcv / 4) % 2;
        c = (nzcv / 2) % 2;
        v = nzcv % 2;
        case (cond / 2)
            0: base = (z == 1);
            1: base = (c == 1);
            2: base = (n == 1);
            3: base = (v == 1);
            4: base = (c == 1) && (z == 0);
            5: base = (n == v);
            6: base = (z == 0) && (n == v);
            default: return (cond == 14) ? 1'b1 : !nv_never;
        endcase
        return (cond % 2 == 1) ? !base : base;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check handshake, advance model, check registered outputs.
    task automatic cyc(input bit rst, input bit iss, input bit we, input int fin,
                       input bit cv, input int cond, input bit rr);
        bit exp_ready, clear, acc;
        int ef, np;
        reset       = rst;
        FLAGS_ISSUE = iss;
        FLAGS_WE    = we;
        FLAGS_IN    = 4'(fin);
        COND_VALID  = cv;
        COND        = 4'(cond);
        RESP_READY  = rr;
        #1;
        exp_ready = !m_wait && (!m_rv || rr);
        if (!rst) begin
            chk("cond_ready", 8'(COND_READY), 8'(exp_ready));
            chk("cond_ready_nv0", 8'(COND_READY1), 8'(exp_ready));
        end
        clear = (m_pend == 0) || (m_pend == 1 && we && !iss);
        ef    = we ? fin : m_flags;
        acc   = cv && exp_ready;
        if (rst) begin
            m_flags = 0; m_pend = 0; m_wcond = 0;
            m_err = 0; m_wait = 0; m_rv = 0; m_pass_nv1 = 0; m_pass_nv0 = 0;
        end else begin
            if (m_wait) begin
                if (clear) begin
                    m_wait = 0;
                    m_rv = 1;
                    m_pass_nv1 = ref_pass(m_wcond, ef, 1'b1);
                    m_pass_nv0 = ref_pass(m_wcond, ef, 1'b0);
                end
            end else if (!(m_rv && !rr)) begin
                m_rv = 0;
                if (acc) begin
                    if (clear) begin
                        m_rv = 1;
                        m_pass_nv1 = ref_pass(cond, ef, 1'b1);
                        m_pass_nv0 = ref_pass(cond, ef, 1'b0);
                    end else begin
                        m_wait  = 1;
                        m_wcond = cond;
                    end
                end
            end
            if (we) m_flags = fin;
            np = m_pend + int'(iss) - int'(we);
            if (np < 0) np = 0;
            if (np > PMAX) begin
                np = PMAX;
                m_err = 1;
            end
            m_pend = np;
        end
        @(posedge clk);
        #1;
        chk("flags", 8'(FLAGS), 8'(m_flags));
        chk("pending", 8'(PENDING), 8'(m_pend));
        chk("pend_err", 8'(PEND_ERR), 8'(m_err));
        chk("resp_valid", 8'(RESP_VALID), 8'(m_rv));
        chk("pass", 8'(PASS), 8'(m_pass_nv1));
        chk("pass_nv0", 8'(PASS1), 8'(m_pass_nv0));
        chk("resp_valid_nv0", 8'(RESP_VALID1), 8'(m_rv));
        chk("flags_nv0", 8'(FLAGS1), 8'(m_flags));
        chk("pending_nv0", 8'(PENDING1), 8'(m_pend));
        chk("pend_err_nv0", 8'(PEND_ERR1), 8'(m_err));
    endtask

    initial begin
        m_flags = 0; m_pend = 0; m_wcond = 0;
        m_err = 0; m_wait = 0; m_rv = 0; m_pass_nv1 = 0; m_pass_nv0 = 0;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("rst_flags", 8'(FLAGS), 8'h0);
        chk("rst_rv", 8'(RESP_VALID), 8'h0);
        chk("rst_pass", 8'(PASS), 8'h0);

        // Direct write forwarded into EQ evaluation
        cyc(0, 0, 1, 4'b0100, 1, 0, 1);
        chk("t1_rv", 8'(RESP_VALID), 8'h1);
        chk("t1_pass", 8'(PASS), 8'h1);
        chk("t1_flags", 8'(FLAGS), 8'h4);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // Every condition against every NZCV, back to back
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                cyc(0, 0, 1, f, 1, c, 1);
                if (c == 15) begin
                    chk("t2_nv_never1", 8'(PASS), 8'h0);
                    chk("t2_nv_never0", 8'(PASS1), 8'h1);
                end
            end
        end
        cyc(0, 0, 0, 0, 0, 0, 1);

        // Hazard stall until the in-flight writer lands
        cyc(0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 10, 1);
        chk("t3_rv_wait", 8'(RESP_VALID), 8'h0);
        chk("t3_ready_wait", 8'(COND_READY), 8'h0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 4'b1001, 0, 0, 1);
        chk("t3_rv", 8'(RESP_VALID), 8'h1);
        chk("t3_pass", 8'(PASS), 8'h1);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // Landing write in the accept cycle is forwarded
        cyc(0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 4'b0000, 1, 1, 1);
        chk("t4_pass", 8'(PASS), 8'h1);
        chk("t4_pending", 8'(PENDING), 8'h0);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // Backpressure holds PASS through a flag change, then back-to-back
        cyc(0, 0, 1, 4'b0100, 1, 0, 0);
        cyc(0, 0, 1, 4'b0000, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t5_hold_rv", 8'(RESP_VALID), 8'h1);
        chk("t5_hold_pass", 8'(PASS), 8'h1);
        cyc(0, 0, 0, 0, 1, 0, 1);
        chk("t5_b2b_rv", 8'(RESP_VALID), 8'h1);
        chk("t5_b2b_pass", 8'(PASS), 8'h0);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // Counter saturation, underflow guard, reset in WAIT
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0, 1);
        chk("t6_pend_max", 8'(PENDING), 8'h3);
        chk("t6_err", 8'(PEND_ERR), 8'h1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 1);
        chk("t6_pend_zero", 8'(PENDING), 8'h0);
        cyc(0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 3, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("t6_rst_rv", 8'(RESP_VALID), 8'h0);
        chk("t6_rst_pend", 8'(PENDING), 8'h0);
        chk("t6_rst_err", 8'(PEND_ERR), 8'h0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t6_no_resp", 8'(RESP_VALID), 8'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 300) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
                int'($urandom % 16), ($urandom % 2) == 0, int'($urandom % 16),
                ($urandom % 4) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
